hpm_overflow: RTL and testbench
===============================

Name: hpm_overflow

Overview:
- Sscofpmf companion to the counter CSR block. Owns mhpmevent3..N (and mhpmeventh on RV32): event selector, per-mode inhibit bits and sticky overflow (OF) bit.
- Produces per-counter count-gate masks, consumed by the counter block alongside mcountinhibit.
- Detects counter wrap and raises a one-cycle local-counter-overflow interrupt set pulse (mip.LCOFIP, bit 13) to the interrupt/CSR-status logic.

Parameters:
- XLEN, 64, integer register width (32 or 64).
- COUNTERS, 32, number of implemented hpm counters (4..32); only indices 3..COUNTERS-1 get event registers.
- EVSELBITS, 8, width of the implemented event-selector field (WARL).
- MAXEVENT, 24, highest legal selector value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- CSRMWriteM  in  1  M-mode CSR write strobe, already qualified by valid/not-flushed
- CSRAdrM  in  12  CSR address
- CSRWriteValM  in  XLEN  write data
- PrivilegeModeW  in  2  current privilege (M=3, S=1, U=0)
- CounterIncM  in  COUNTERS  counter i increments this cycle (post-gating)
- CounterAllOnesM  in  COUNTERS  counter i currently all ones (64-bit)
- CounterWriteM  in  COUNTERS  software writing counter i this cycle
- CountGateM  out  COUNTERS  1 = counter i may count in the current mode
- EventSelM  out  COUNTERS*EVSELBITS  selector field per counter, flattened
- LCOFISetM  out  1  registered pulse: set mip.LCOFIP
- OFVecM  out  COUNTERS  current OF bits (for scountovf)
- HPMReadValM  out  XLEN  read data
- HPMHitM  out  1  CSRAdrM decodes to a register owned here

Behaviour:
- State per counter i in 3..COUNTERS-1: OF[i], MINH[i], SINH[i], UINH[i], SEL[i][EVSELBITS-1:0]. Indices 0..2 and those at or above COUNTERS: no state; read 0; CountGateM=1; OF=0.
- Reset: all state cleared. Outputs on reset: CountGateM all ones, EventSelM=0, LCOFISetM=0, OFVecM=0.
- Address map: mhpmevent i at 0x320+i, i=3..31. RV32 adds mhpmeventh at 0x720+i.
- Bit placement: OF/MINH/SINH/UINH are bits 63/62/61/60 of the 64-bit view (RV32: mhpmeventh bits 31/30/29/28). SEL is bits EVSELBITS-1:0 of mhpmevent.
- HPMHitM=1 for any 0x323–0x33F, or 0x723–0x73F on RV32 only. Registers for i>=COUNTERS are hit but read 0 and ignore writes.
- Reads: combinational, unimplemented bits read 0.
- Write rules:
  - Writes take effect on the next edge when CSRMWriteM and the address match.
  - SEL is WARL: a value above MAXEVENT writes 0.
  - An RV32 low-half write leaves the flags untouched; an RV32 high-half write leaves SEL untouched.
- Gating: CountGateM[i] = ~((PrivilegeModeW==3 & MINH[i]) | (PrivilegeModeW==1 & SINH[i]) | (PrivilegeModeW==0 & UINH[i])).
- Overflow condition: OvfM[i] = CounterIncM[i] & CounterAllOnesM[i] & ~CounterWriteM[i].
- On an overflow edge: OF[i] is set. If OF[i] was 0 before, LCOFISetM=1 exactly one cycle after the wrapping increment (registered).
  - Overflow with OF already 1: no new pulse.
  - Several counters overflowing in the same cycle: a single pulse, all affected OF bits set.
- Simultaneous software write to mhpmevent i and overflow of i: the overflow wins for OF (set, pulse generated); the other fields take the written value.
- Software write of OF=1 sets OF without a pulse; OF=0 clears it.
- Reset mid-pulse: LCOFISetM drops on the reset edge; a pending overflow on that cycle is lost.
- Latency: gating and reads 0 cycles; OF visible 1 cycle after the wrap; LCOFISetM 1 cycle after the wrap.

Optional Feature:
- Macro: HPM_MODE_INHIBIT_EN.
- Defined: MINH/SINH/UINH are implemented as above.
- Undefined: MINH/SINH/UINH are not stored, read 0 and ignore writes; CountGateM is tied to all ones. OF, SEL and LCOFI behaviour are unchanged.

Test Plan:
- Reset, then read 0x323..0x33F (COUNTERS=32) -> all 0, HPMHitM=1; CountGateM=0xFFFFFFFF; LCOFISetM=0.
- Write 0x325 = 0x4000_0000_0000_0005 (MINH, SEL=5) in M-mode -> readback equal, EventSelM[5]=5, CountGateM[5]=0. Switch to S-mode -> CountGateM[5]=1.
- Write SEL=0xFF (MAXEVENT=24) -> readback SEL=0.
- Counter 4: CounterAllOnesM[4]=1, CounterIncM[4]=1 for one cycle -> OF[4]=1 next cycle, LCOFISetM one-cycle pulse. Repeat with OF set -> no pulse.
- Counters 3 and 7 wrap in the same cycle -> single LCOFISetM pulse, OFVecM=0x88. Wrap of counter 3 with CounterWriteM[3]=1 -> no OF, no pulse.
- RV32 (XLEN=32): write 0x726 = 0x8000_0000 -> OF[6]=1, no pulse, SEL unchanged. Overflow of 6 coinciding with a write of 0 to 0x726 -> OF[6]=1 and pulse.

Source files
------------

// File: rtl/hpm_overflow_if.sv
// CSR access bundle between the CSR decode stage and the hpm_overflow block.
// Latency: combinational read path; the write takes effect on the next clk edge.
// Backpressure: none, because the CSR strobe is a single-cycle, always-accepted request.
interface hpm_overflow_if #(
   parameter int XLEN = 64
);
   logic            CSRMWriteM;    // M-mode CSR write strobe, already qualified
   logic [11:0]     CSRAdrM;       // CSR address
   logic [XLEN-1:0] CSRWriteValM;  // write data
   logic [XLEN-1:0] HPMReadValM;   // read data from the event registers
   logic            HPMHitM;       // address belongs to this block

   // CSR decode side drives the request
   modport master (
      output CSRMWriteM, CSRAdrM, CSRWriteValM,
      input  HPMReadValM, HPMHitM
   );

   // hpm_overflow side answers
   modport slave (
      input  CSRMWriteM, CSRAdrM, CSRWriteValM,
      output HPMReadValM, HPMHitM
   );
endinterface

// File: rtl/hpm_overflow.sv
// Sscofpmf mhpmevent state: selector, mode inhibits, sticky OF, count gates and LCOFI set pulse.
// Latency: gates/reads 0 cycles; OF and LCOFISetM 1 cycle after the wrapping increment.
// Backpressure: none; HPM_MODE_INHIBIT_EN enables MINH/SINH/UINH storage (else gates tied high).
module hpm_overflow #(
   parameter int XLEN      = 64,
   parameter int COUNTERS  = 32,
   parameter int EVSELBITS = 8,
   parameter int MAXEVENT  = 24
) (
   input  logic                          clk,
   input  logic                          reset,
   hpm_overflow_if.slave                 csr,
   input  logic [1:0]                    PrivilegeModeW,
   input  logic [COUNTERS-1:0]           CounterIncM,
   input  logic [COUNTERS-1:0]           CounterAllOnesM,
   input  logic [COUNTERS-1:0]           CounterWriteM,
   output logic [COUNTERS-1:0]           CountGateM,
   output logic [COUNTERS*EVSELBITS-1:0] EventSelM,
   output logic                          LCOFISetM,
   output logic [COUNTERS-1:0]           OFVecM
);

   // Counters 0..2 (cycle, time, instret) own no event register.
   localparam logic [COUNTERS-1:0]  IMPL_MASK = {{(COUNTERS-3){1'b1}}, 3'b000};
   localparam logic [EVSELBITS-1:0] MAXSEL    = EVSELBITS'(MAXEVENT);

   // ---------------- address decode ----------------
   logic [4:0]          idx;
   logic                in_range;
   logic                hit_lo;
   logic                hit_hi;
   logic [COUNTERS-1:0] sel_idx;
   logic [COUNTERS-1:0] wr_lo;
   logic [COUNTERS-1:0] wr_hi;
   logic [COUNTERS-1:0] flag_wr;

   assign idx      = csr.CSRAdrM[4:0];
   assign in_range = (idx >= 5'd3);
   // 0x320..0x33F share address bits [11:5]; mhpmeventh lives at 0x720..0x73F on RV32.
   assign hit_lo   = (csr.CSRAdrM[11:5] == 7'h19) & in_range;
   assign hit_hi   = (XLEN == 32) & (csr.CSRAdrM[11:5] == 7'h39) & in_range;
   assign csr.HPMHitM = hit_lo | hit_hi;

   // One-hot select of the implemented register addressed; empty for indices >= COUNTERS.
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < COUNTERS; i++) begin
         sel_idx[i] = (idx == 5'(i)) & IMPL_MASK[i];
      end
   end

   assign wr_lo   = {COUNTERS{csr.CSRMWriteM & hit_lo}} & sel_idx;
   assign wr_hi   = {COUNTERS{csr.CSRMWriteM & hit_hi}} & sel_idx;
   // Flags sit in the upper 4 bits of mhpmevent on RV64, of mhpmeventh on RV32.
   assign flag_wr = (XLEN == 64) ? wr_lo : wr_hi;

   // ---------------- write data ----------------
   logic [3:0]           wflags;     // {OF, MINH, SINH, UINH}
   logic [EVSELBITS-1:0] wsel;
   logic [EVSELBITS-1:0] wsel_legal;

   assign wflags     = csr.CSRWriteValM[XLEN-1 -: 4];
   assign wsel       = csr.CSRWriteValM[EVSELBITS-1:0];
   assign wsel_legal = (wsel > MAXSEL) ? '0 : wsel;

   // ---------------- overflow detect ----------------
   // A software write to the counter in the same cycle replaces the wrap.
   logic [COUNTERS-1:0] ovf;
   assign ovf = CounterIncM & CounterAllOnesM & ~CounterWriteM & IMPL_MASK;

   // ---------------- state ----------------
   logic [COUNTERS-1:0]  of_q,  of_d;
   logic [EVSELBITS-1:0] sel_q [COUNTERS];
   logic [EVSELBITS-1:0] sel_d [COUNTERS];
   logic                 lcofi_q, lcofi_d;
   logic [COUNTERS-1:0]  minh, sinh, uinh;

   // OF: software write applies first, a wrap in the same cycle overrides it to 1.
   always_comb begin
      of_d    = ((of_q & ~flag_wr) | (flag_wr & {COUNTERS{wflags[3]}})) | ovf;
      // Only a 0->1 transition caused by a wrap raises the interrupt; all wraps merge.
      lcofi_d = |(ovf & ~of_q);
      sel_d   = sel_q;
      for (int i = 0; i < COUNTERS; i++) begin
         if (wr_lo[i]) sel_d[i] = wsel_legal;
      end
   end

   // OF, selector and pulse registers; reset also drops a pulse in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         of_q    <= '0;
         lcofi_q <= 1'b0;
         sel_q   <= '{default: '0};
      end else begin
         of_q    <= of_d;
         lcofi_q <= lcofi_d;
         sel_q   <= sel_d;
      end
   end

`ifdef HPM_MODE_INHIBIT_EN
   logic [COUNTERS-1:0] minh_q, minh_d;
   logic [COUNTERS-1:0] sinh_q, sinh_d;
   logic [COUNTERS-1:0] uinh_q, uinh_d;
   logic                priv_m, priv_s, priv_u;

   // Inhibit bits follow the flag write; untouched otherwise.
   always_comb begin
      minh_d = (minh_q & ~flag_wr) | (flag_wr & {COUNTERS{wflags[2]}});
      sinh_d = (sinh_q & ~flag_wr) | (flag_wr & {COUNTERS{wflags[1]}});
      uinh_d = (uinh_q & ~flag_wr) | (flag_wr & {COUNTERS{wflags[0]}});
   end

   // Inhibit registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         minh_q <= '0;
         sinh_q <= '0;
         uinh_q <= '0;
      end else begin
         minh_q <= minh_d;
         sinh_q <= sinh_d;
         uinh_q <= uinh_d;
      end
   end

   assign minh   = minh_q;
   assign sinh   = sinh_q;
   assign uinh   = uinh_q;
   assign priv_m = (PrivilegeModeW == 2'd3);
   assign priv_s = (PrivilegeModeW == 2'd1);
   assign priv_u = (PrivilegeModeW == 2'd0);

   // A counter may count unless the inhibit bit of the current mode is set.
   always_comb begin
      CountGateM = ~(({COUNTERS{priv_m}} & minh_q) |
                     ({COUNTERS{priv_s}} & sinh_q) |
                     ({COUNTERS{priv_u}} & uinh_q));
   end

   logic unused_bits;
   assign unused_bits = ^{csr.CSRWriteValM};
`else
   // Mode inhibits are not stored in this build: they read 0 and every counter is always allowed.
   assign minh       = '0;
   assign sinh       = '0;
   assign uinh       = '0;
   assign CountGateM = '1;

   logic unused_bits;
   assign unused_bits = ^{csr.CSRWriteValM, PrivilegeModeW, wflags[2:0]};
`endif

   // ---------------- read path ----------------
   logic [XLEN-1:0] rd_val;

   // Combinational read of the addressed half; unimplemented bits and registers read 0.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < COUNTERS; i++) begin
         if (sel_idx[i]) begin
            if (hit_lo) rd_val[EVSELBITS-1:0] = sel_q[i];
            if ((hit_lo && (XLEN == 64)) || hit_hi)
               rd_val[XLEN-1 -: 4] = {of_q[i], minh[i], sinh[i], uinh[i]};
         end
      end
   end

   assign csr.HPMReadValM = rd_val;

   // Flatten the per-counter selectors for the event mux in the counter block.
   always_comb begin
      EventSelM = '0;
      for (int i = 0; i < COUNTERS; i++) begin
         EventSelM[i*EVSELBITS +: EVSELBITS] = sel_q[i];
      end
   end

   assign LCOFISetM = lcofi_q;
   assign OFVecM    = of_q;

endmodule

// File: tb/tb_hpm_overflow.sv
// Directed bench for hpm_overflow: an RV64 instance (32 counters) and an RV32 instance (8 counters).
// Latency: checks combinational paths 1-3 time units after a drive, registered state 2 units after posedge.
// Backpressure: none; all stimulus is driven at negedge by fixed vectors.
module tb_hpm_overflow;

`ifdef HPM_MODE_INHIBIT_EN
   localparam bit INH = 1'b1;
`else
   localparam bit INH = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [1:0]  priv;

   logic [31:0] inc64, ones64, cwr64, gate64, ofv64;
   logic [255:0] ev64;
   logic        lc64;

   logic [7:0]  inc32, ones32, cwr32, gate32, ofv32;
   logic [63:0] ev32;
   logic        lc32;

   int total;
   int bad;

   hpm_overflow_if #(.XLEN(64)) if64 ();
   hpm_overflow_if #(.XLEN(32)) if32 ();

   hpm_overflow #(.XLEN(64), .COUNTERS(32), .EVSELBITS(8), .MAXEVENT(24)) u64 (
      .clk(clk), .reset(reset), .csr(if64.slave), .PrivilegeModeW(priv),
      .CounterIncM(inc64), .CounterAllOnesM(ones64), .CounterWriteM(cwr64),
      .CountGateM(gate64), .EventSelM(ev64), .LCOFISetM(lc64), .OFVecM(ofv64));

   hpm_overflow #(.XLEN(32), .COUNTERS(8), .EVSELBITS(8), .MAXEVENT(24)) u32 (
      .clk(clk), .reset(reset), .csr(if32.slave), .PrivilegeModeW(priv),
      .CounterIncM(inc32), .CounterAllOnesM(ones32), .CounterWriteM(cwr32),
      .CountGateM(gate32), .EventSelM(ev32), .LCOFISetM(lc32), .OFVecM(ofv32));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One cycle of stimulus on the RV64 instance, then everything back to idle.
   task automatic step64(input logic we, input logic [11:0] a, input logic [63:0] v,
                         input logic [31:0] inc, input logic [31:0] ones, input logic [31:0] cw);
      @(negedge clk);
      if64.CSRMWriteM = we; if64.CSRAdrM = a; if64.CSRWriteValM = v;
      inc64 = inc; ones64 = ones; cwr64 = cw;
      tick();
      if64.CSRMWriteM = 1'b0; inc64 = '0; ones64 = '0; cwr64 = '0;
   endtask

   task automatic step32(input logic we, input logic [11:0] a, input logic [31:0] v,
                         input logic [7:0] inc, input logic [7:0] ones, input logic [7:0] cw);
      @(negedge clk);
      if32.CSRMWriteM = we; if32.CSRAdrM = a; if32.CSRWriteValM = v;
      inc32 = inc; ones32 = ones; cwr32 = cw;
      tick();
      if32.CSRMWriteM = 1'b0; inc32 = '0; ones32 = '0; cwr32 = '0;
   endtask

   task automatic rd64(input logic [11:0] a);
      if64.CSRAdrM = a;
      #1;
   endtask

   task automatic rd32(input logic [11:0] a);
      if32.CSRAdrM = a;
      #1;
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; priv = 2'd3;
      if64.CSRMWriteM = 1'b0; if64.CSRAdrM = '0; if64.CSRWriteValM = '0;
      if32.CSRMWriteM = 1'b0; if32.CSRAdrM = '0; if32.CSRWriteValM = '0;
      inc64 = '0; ones64 = '0; cwr64 = '0;
      inc32 = '0; ones32 = '0; cwr32 = '0;
      repeat (3) tick();
      @(negedge clk);
      reset = 1'b0;
      tick();

      // ---------- reset state, RV64 ----------
      chk("rst_gate64", 64'(gate64), 64'hFFFF_FFFF);
      chk("rst_lc64", 64'(lc64), 64'd0);
      chk("rst_ofv64", 64'(ofv64), 64'd0);
      chk("rst_ev64", 64'(|ev64), 64'd0);
      for (int i = 3; i < 32; i++) begin
         rd64(12'(12'h320 + i));
         chk("rst_rd64", if64.HPMReadValM, 64'd0);
         chk("rst_hit64", 64'(if64.HPMHitM), 64'd1);
      end
      rd64(12'h321); chk("nohit_321", 64'(if64.HPMHitM), 64'd0);
      rd64(12'h340); chk("nohit_340", 64'(if64.HPMHitM), 64'd0);
      rd64(12'h723); chk("nohit_723_rv64", 64'(if64.HPMHitM), 64'd0);

      // ---------- MINH + SEL, mode gating ----------
      step64(1'b1, 12'h325, 64'h4000_0000_0000_0005, '0, '0, '0);
      rd64(12'h325);
      chk("rd_325", if64.HPMReadValM, INH ? 64'h4000_0000_0000_0005 : 64'h5);
      chk("evsel5", 64'(ev64[47:40]), 64'h5);
      chk("gate_m", 64'(gate64), INH ? 64'hFFFF_FFDF : 64'hFFFF_FFFF);
      priv = 2'd1; #1;
      chk("gate_s", 64'(gate64), 64'hFFFF_FFFF);
      priv = 2'd3; #1;

      // ---------- WARL selector ----------
      step64(1'b1, 12'h325, 64'hFF, '0, '0, '0);
      rd64(12'h325); chk("warl_ff", if64.HPMReadValM, 64'd0);
      chk("gate_cleared", 64'(gate64), 64'hFFFF_FFFF);
      step64(1'b1, 12'h327, 64'd24, '0, '0, '0);
      rd64(12'h327); chk("warl_24", if64.HPMReadValM, 64'd24);
      step64(1'b1, 12'h327, 64'd25, '0, '0, '0);
      rd64(12'h327); chk("warl_25", if64.HPMReadValM, 64'd0);

      // ---------- single wrap of counter 4 ----------
      step64(1'b0, 12'h0, 64'd0, 32'h10, 32'h10, '0);
      chk("ovf4_lc", 64'(lc64), 64'd1);
      chk("ovf4_ofv", 64'(ofv64), 64'h10);
      rd64(12'h324); chk("ovf4_rd", if64.HPMReadValM, 64'h8000_0000_0000_0000);
      tick();
      chk("ovf4_lc_drop", 64'(lc64), 64'd0);
      step64(1'b0, 12'h0, 64'd0, 32'h10, 32'h10, '0);
      chk("ovf4_again_lc", 64'(lc64), 64'd0);
      chk("ovf4_again_ofv", 64'(ofv64), 64'h10);

      // increment without all-ones, and a wrap on a counter without event register
      step64(1'b0, 12'h0, 64'd0, 32'h100, '0, '0);
      chk("inc_no_wrap", 64'(ofv64), 64'h10);
      step64(1'b0, 12'h0, 64'd0, 32'h4, 32'h4, '0);
      chk("ovf2_lc", 64'(lc64), 64'd0);
      chk("ovf2_ofv", 64'(ofv64), 64'h10);

      // ---------- clear OF, dual wrap, wrap masked by counter write ----------
      step64(1'b1, 12'h324, 64'd0, '0, '0, '0);
      chk("clr4_ofv", 64'(ofv64), 64'd0);
      step64(1'b0, 12'h0, 64'd0, 32'h88, 32'h88, '0);
      chk("dual_lc", 64'(lc64), 64'd1);
      chk("dual_ofv", 64'(ofv64), 64'h88);
      tick();
      chk("dual_lc_drop", 64'(lc64), 64'd0);
      step64(1'b1, 12'h323, 64'd0, '0, '0, '0);
      step64(1'b0, 12'h0, 64'd0, 32'h8, 32'h8, 32'h8);
      chk("cwr3_ofv", 64'(ofv64), 64'h80);
      chk("cwr3_lc", 64'(lc64), 64'd0);

      // ---------- software OF set, write racing a wrap ----------
      step64(1'b1, 12'h32C, 64'h8000_0000_0000_0000, '0, '0, '0);
      chk("swof_ofv", 64'(ofv64), 64'h1080);
      chk("swof_lc", 64'(lc64), 64'd0);
      step64(1'b1, 12'h325, 64'h7, 32'h20, 32'h20, '0);
      chk("race_ofv", 64'(ofv64), 64'h10A0);
      chk("race_lc", 64'(lc64), 64'd1);
      rd64(12'h325); chk("race_rd", if64.HPMReadValM, 64'h8000_0000_0000_0007);

      // ---------- RV32 instance ----------
      chk("rst_gate32", 64'(gate32), 64'hFF);
      chk("rst_lc32", 64'(lc32), 64'd0);
      rd32(12'h723); chk("hit_723", 64'(if32.HPMHitM), 64'd1);
      rd32(12'h72A); chk("hit_72a", 64'(if32.HPMHitM), 64'd1);
      chk("rd_72a", 64'(if32.HPMReadValM), 64'd0);
      rd32(12'h33F); chk("hit_33f", 64'(if32.HPMHitM), 64'd1);
      rd32(12'h740); chk("nohit_740", 64'(if32.HPMHitM), 64'd0);

      step32(1'b1, 12'h326, 32'h5, '0, '0, '0);
      rd32(12'h326); chk("rv32_sel", 64'(if32.HPMReadValM), 64'h5);
      chk("rv32_evsel6", 64'(ev32[55:48]), 64'h5);
      step32(1'b1, 12'h726, 32'h8000_0000, '0, '0, '0);
      chk("rv32_swof_ofv", 64'(ofv32), 64'h40);
      chk("rv32_swof_lc", 64'(lc32), 64'd0);
      rd32(12'h726); chk("rv32_rdh", 64'(if32.HPMReadValM), 64'h8000_0000);
      rd32(12'h326); chk("rv32_sel_kept", 64'(if32.HPMReadValM), 64'h5);

      step32(1'b1, 12'h326, 32'hFFFF_FF03, '0, '0, '0);
      rd32(12'h726); chk("rv32_lo_keeps_flags", 64'(if32.HPMReadValM), 64'h8000_0000);
      rd32(12'h326); chk("rv32_lo_sel", 64'(if32.HPMReadValM), 64'h3);
      step32(1'b1, 12'h726, 32'h0, '0, '0, '0);
      chk("rv32_clr_ofv", 64'(ofv32), 64'd0);
      rd32(12'h326); chk("rv32_hi_keeps_sel", 64'(if32.HPMReadValM), 64'h3);

      step32(1'b1, 12'h726, 32'h0, 8'h40, 8'h40, '0);
      chk("rv32_race_ofv", 64'(ofv32), 64'h40);
      chk("rv32_race_lc", 64'(lc32), 64'd1);
      tick();
      chk("rv32_race_lc_drop", 64'(lc32), 64'd0);

      step32(1'b1, 12'h72A, 32'h8000_0000, '0, '0, '0);
      rd32(12'h72A); chk("rv32_unimpl_rd", 64'(if32.HPMReadValM), 64'd0);
      chk("rv32_unimpl_ofv", 64'(ofv32), 64'h40);

      step32(1'b1, 12'h726, 32'h1000_0000, '0, '0, '0);
      priv = 2'd0; #1;
      chk("rv32_gate_u", 64'(gate32), INH ? 64'hBF : 64'hFF);
      rd32(12'h726); chk("rv32_uinh_rd", 64'(if32.HPMReadValM), INH ? 64'h1000_0000 : 64'd0);
      priv = 2'd3; #1;

      // ---------- reset during a pulse drops it and loses a coincident wrap ----------
      step64(1'b0, 12'h0, 64'd0, 32'h200, 32'h200, '0);
      chk("pre_rst_lc", 64'(lc64), 64'd1);
      @(negedge clk);
      reset = 1'b1; inc64 = 32'h400; ones64 = 32'h400;
      tick();
      chk("rst_pulse_lc", 64'(lc64), 64'd0);
      chk("rst_pulse_ofv", 64'(ofv64), 64'd0);
      @(negedge clk);
      reset = 1'b0; inc64 = '0; ones64 = '0;
      tick();
      chk("post_rst_lc", 64'(lc64), 64'd0);
      rd64(12'h325); chk("post_rst_rd", if64.HPMReadValM, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
